// File: rtl/y86_iram_loader.sv
// Framed byte-stream loader for the y86 instruction memory byte write port.
// Parses SYNC/ADDR/LEN headers, writes the payload, and verifies an XOR checksum.
module y86_iram_loader #(
  parameter int unsigned SIZE = 4096,
  parameter logic [7:0]  SYNC = 8'hA5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [7:0]  wr_data,
  input  logic        wr_ready,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam logic [16:0] ADDR_MASK = 17'(SIZE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A0,
    ST_A1,
    ST_L0,
    ST_L1,
    ST_DATA,
    ST_CSUM
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] base_q, base_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] rem_q, rem_d;
  logic [7:0]  csum_q, csum_d;
  logic        buf_full_q, buf_full_d;
  logic [16:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        accept;
  logic        wr_done;
  logic [15:0] len_full;
  logic [16:0] addr_sum;

  assign accept   = in_valid && in_ready;
  assign wr_done  = buf_full_q && wr_ready;
  assign len_full = {in_data, len_lo_q};
  assign addr_sum = {1'b0, base_q} + {1'b0, idx_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      unique case (state_q)
        ST_IDLE: if (in_data == SYNC) state_d = ST_A0;
        ST_A0:   state_d = ST_A1;
        ST_A1:   state_d = ST_L0;
        ST_L0:   state_d = ST_L1;
        ST_L1:   state_d = (len_full == 16'd0) ? ST_CSUM : ST_DATA;
        ST_DATA: if (rem_q == 16'd1) state_d = ST_CSUM;
        ST_CSUM: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // In DATA a completing write frees the buffer, so a new byte can land back-to-back.
  always_comb begin
    in_ready = 1'b1;
    unique case (state_q)
      ST_DATA: in_ready = !buf_full_q || wr_ready;
      ST_CSUM: in_ready = !buf_full_q;
      default: in_ready = 1'b1;
    endcase
  end

  always_comb begin
    base_d     = base_q;
    len_lo_d   = len_lo_q;
    idx_d      = idx_q;
    rem_d      = rem_q;
    csum_d     = csum_q;
    buf_full_d = buf_full_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    hold_d     = hold_q;
    done_d     = 1'b0;
    err_d      = err_q;

    if (wr_done) begin
      buf_full_d = 1'b0;
    end

    if (accept) begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_data == SYNC) begin
            hold_d = 1'b1;
            err_d  = 1'b0;
            csum_d = 8'h00;
            idx_d  = 16'd0;
          end
        end
        ST_A0: base_d[7:0]  = in_data;
        ST_A1: base_d[15:8] = in_data;
        ST_L0: len_lo_d     = in_data;
        ST_L1: rem_d        = len_full;
        ST_DATA: begin
          buf_full_d = 1'b1;
          wr_addr_d  = addr_sum & ADDR_MASK;
          wr_data_d  = in_data;
          csum_d     = csum_q ^ in_data;
          idx_d      = idx_q + 16'd1;
          rem_d      = rem_q - 16'd1;
        end
        ST_CSUM: begin
          hold_d = 1'b0;
          if (csum_q == in_data) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q     <= 16'd0;
      len_lo_q   <= 8'd0;
      idx_q      <= 16'd0;
      rem_q      <= 16'd0;
      csum_q     <= 8'd0;
      buf_full_q <= 1'b0;
      wr_addr_q  <= 17'd0;
      wr_data_q  <= 8'd0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      base_q     <= base_d;
      len_lo_q   <= len_lo_d;
      idx_q      <= idx_d;
      rem_q      <= rem_d;
      csum_q     <= csum_d;
      buf_full_q <= buf_full_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign wr_en    = buf_full_q;
  assign wr_addr  = {15'd0, wr_addr_q};
  assign wr_data  = wr_data_q;
  assign cpu_hold = hold_q;
  assign done     = done_q;
  assign error    = err_q;

endmodule

// File: tb/tb_y86_iram_loader.sv
// Directed bench for y86_iram_loader: a frame-level model predicts every write,
// and a per-cycle checker compares write handshakes, hold stability and done/error.
module tb_y86_iram_loader;

  localparam int SIZE = 4096;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ready = 1'b1;
  logic        cpu_hold;
  logic        done;
  logic        error;

  y86_iram_loader #(.SIZE(SIZE), .SYNC(8'hA5)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  int cmp_cnt = 0;
  int fail_cnt = 0;
  int cyc = 0;
  int stall_cnt = 0;
  int done_cnt = 0;
  bit bp_mode = 1'b0;
  wr_t exp_q[$];
  wr_t obs_q[$];
  int  obs_cyc[$];
  logic [7:0] pl[$];

  logic        pend = 1'b0;
  logic [31:0] pend_addr;
  logic [7:0]  pend_data;
  wr_t         cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      wr_ready = bp_mode ? ~wr_ready : 1'b1;
    end
  end

  // Per-cycle checker, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          chk("held_wr_en", {31'd0, wr_en}, 32'd1);
          chk("held_wr_addr", wr_addr, pend_addr);
          chk("held_wr_data", {24'd0, wr_data}, {24'd0, pend_data});
        end
        if (wr_en && wr_ready) begin
          chk("write_cpu_hold", {31'd0, cpu_hold}, 32'd1);
          if (exp_q.size() == 0) begin
            cmp_cnt++;
            fail_cnt++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, want no write", wr_addr, wr_data);
          end else begin
            cur = exp_q.pop_front();
            chk("write_addr", wr_addr, cur.addr);
            chk("write_data", {24'd0, wr_data}, {24'd0, cur.data});
          end
          obs_q.push_back({wr_addr, wr_data});
          obs_cyc.push_back(cyc);
        end
        pend      = wr_en && !wr_ready;
        pend_addr = wr_addr;
        pend_data = wr_data;
        if (in_valid && !in_ready) stall_cnt++;
        if (done) begin
          done_cnt++;
          chk("done_with_error", {31'd0, error}, 32'd0);
          chk("done_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      cmp_cnt++;
      fail_cnt++;
      $display("FAIL send_timeout: in_ready stayed 0 for byte 0x%0h, want 1", b);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [7:0] model_csum();
    logic [7:0] x;
    x = 8'h00;
    foreach (pl[i]) x = x ^ pl[i];
    return x;
  endfunction

  task automatic set_pl4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    pl.delete();
    pl.push_back(a);
    pl.push_back(b);
    pl.push_back(c);
    pl.push_back(d);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
    chk({tag, "_wr_addr"}, wr_addr, 32'd0);
    chk({tag, "_wr_data"}, {24'd0, wr_data}, 32'd0);
    chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  // Sends one whole frame using the payload in pl; expected writes and outcome come from the model.
  task automatic load(input logic [15:0] base, input logic [7:0] csum, input string tag);
    bit ok;
    int n;
    ok = (model_csum() == csum);
    n  = pl.size();
    foreach (pl[i]) exp_q.push_back({32'((32'(base) + i) % SIZE), pl[i]});
    send_byte(8'hA5);
    chk({tag, "_hold_rise"}, {31'd0, cpu_hold}, 32'd1);
    chk({tag, "_error_cleared"}, {31'd0, error}, 32'd0);
    send_byte(base[7:0]);
    send_byte(base[15:8]);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    foreach (pl[i]) send_byte(pl[i]);
    send_byte(csum);
    chk({tag, "_done"}, {31'd0, done}, {31'd0, ok});
    chk({tag, "_error"}, {31'd0, error}, {31'd0, !ok});
    chk({tag, "_hold_fall"}, {31'd0, cpu_hold}, 32'd0);
    chk({tag, "_all_written"}, exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
  endtask

  int d0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("por");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Garbage ahead of a frame is dropped.
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    chk("garbage_hold", {31'd0, cpu_hold}, 32'd0);
    chk("garbage_no_write", obs_q.size(), 32'd0);

    // Basic load.
    set_pl4(8'h01, 8'h02, 8'h03, 8'h04);
    chk("model_csum_basic", {24'd0, model_csum()}, 32'h04);
    d0 = done_cnt;
    load(16'h0010, 8'h04, "basic");
    chk("basic_nwr", obs_q.size(), 32'd4);
    chk("basic_addr0", obs_q[0].addr, 32'h010);
    chk("basic_addr3", obs_q[3].addr, 32'h013);
    chk("basic_data3", {24'd0, obs_q[3].data}, 32'h04);
    chk("basic_back_to_back", obs_cyc[3] - obs_cyc[0], 32'd3);
    chk("basic_done_count", done_cnt - d0, 32'd1);

    // Address wrap past the top of memory.
    obs_q.delete();
    obs_cyc.delete();
    set_pl4(8'h11, 8'h22, 8'h33, 8'h44);
    chk("model_csum_wrap", {24'd0, model_csum()}, 32'h44);
    load(16'h0FFE, 8'h44, "wrap");
    chk("wrap_addr0", obs_q[0].addr, 32'hFFE);
    chk("wrap_addr1", obs_q[1].addr, 32'hFFF);
    chk("wrap_addr2", obs_q[2].addr, 32'h000);
    chk("wrap_addr3", obs_q[3].addr, 32'h001);

    // Write backpressure.
    obs_q.delete();
    obs_cyc.delete();
    stall_cnt = 0;
    d0 = done_cnt;
    bp_mode = 1'b1;
    set_pl4(8'h01, 8'h02, 8'h03, 8'h04);
    load(16'h0010, 8'h04, "bp");
    bp_mode = 1'b0;
    chk("bp_stalled", {31'd0, stall_cnt > 0}, 32'd1);
    chk("bp_nwr", obs_q.size(), 32'd4);
    chk("bp_data1", {24'd0, obs_q[1].data}, 32'h02);
    chk("bp_done_count", done_cnt - d0, 32'd1);

    // Bad checksum: writes land, error is sticky, no done.
    obs_q.delete();
    d0 = done_cnt;
    load(16'h0010, 8'hFF, "badcsum");
    chk("bad_nwr", obs_q.size(), 32'd4);
    repeat (3) @(posedge clk);
    #1;
    chk("bad_error_sticky", {31'd0, error}, 32'd1);
    chk("bad_no_done", done_cnt - d0, 32'd0);

    // Zero-length frame; its SYNC also clears the sticky error.
    obs_q.delete();
    pl.delete();
    d0 = done_cnt;
    load(16'h0000, 8'h00, "zero");
    chk("zero_no_write", obs_q.size(), 32'd0);
    chk("zero_done_count", done_cnt - d0, 32'd1);

    // Reset in the middle of a payload.
    obs_q.delete();
    exp_q.push_back({32'h20, 8'h01});
    send_byte(8'hA5);
    send_byte(8'h20);
    send_byte(8'h00);
    send_byte(8'h04);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h02);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    chk("midrst_pending_exp", exp_q.size(), 32'd0);
    chk("midrst_nwr", obs_q.size(), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h04);
    chk("midrst_tail_ignored", obs_q.size(), 32'd1);
    chk("midrst_tail_hold", {31'd0, cpu_hold}, 32'd0);

    // Fresh frame after reset.
    pl.delete();
    pl.push_back(8'hAA);
    pl.push_back(8'h55);
    load(16'h0030, 8'hFF, "fresh");
    chk("fresh_addr", obs_q[1].addr, 32'h030);
    chk("fresh_data", {24'd0, obs_q[2].data}, 32'h55);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/y86_iram_loader.md
# y86_iram_loader

Byte-stream loader that writes program images into the y86 instruction memory's byte write port. It receives framed bytes over a valid/ready stream from the host link, parses the frame header, and issues one byte write per payload byte. It also verifies an XOR checksum and holds the processor in reset while a load is in progress. It sits between the host link receiver and the instruction memory, alongside the fetch path that reads the same array.

## Interface
- SIZE, 4096: instruction memory depth in bytes; power of two; write addresses wrap modulo SIZE.
- SYNC, 8'hA5: frame start byte.
- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  stream byte valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts in_data this cycle; a byte transfers when in_valid && in_ready.
- wr_en  out  1  memory write request.
- wr_addr  out  32  byte address; always < SIZE.
- wr_data  out  8  byte to write.
- wr_ready  in  1  memory accepts the write this cycle; a write completes when wr_en && wr_ready.
- cpu_hold  out  1  high from SYNC acceptance until DONE/ERROR is reached.
- done  out  1  one-cycle pulse: frame loaded and checksum matched.
- error  out  1  sticky checksum-mismatch flag; cleared on next accepted SYNC.

## Operation
- Frame format: SYNC, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, N payload bytes, CSUM. Base address and N are 16-bit little-endian. CSUM is the XOR of all payload bytes, with a 0x00 seed.
- States: IDLE -> A0 -> A1 -> L0 -> L1 -> DATA -> CSUM -> IDLE.
- IDLE: bytes other than SYNC are consumed and discarded. SYNC moves to A0, sets cpu_hold, clears error, and zeroes the running checksum.
- A0/A1/L0/L1: each accepted byte is latched into the address or length register, then the FSM advances one state.
- Leaving L1: if N == 0, go to CSUM; otherwise go to DATA with remaining count = N.
- DATA: each accepted byte is loaded into a one-entry write buffer.
  - wr_addr = (base + index) mod SIZE; index starts at 0.
  - The running checksum is XORed with the byte, index increments and remaining count decrements.
  - When the last byte is accepted, go to CSUM.
- CSUM: a byte is accepted only when the write buffer is empty.
  - Match: pulse done, drop cpu_hold, go to IDLE.
  - Mismatch: set error, drop cpu_hold, go to IDLE. Bytes already written are not rolled back.
- in_ready is 1 in IDLE, A0–L1, and CSUM, except that in CSUM it is held 0 while the buffer is occupied.
- In DATA, in_ready is 1 when the buffer is empty, or when it is occupied and wr_ready is 1 this cycle (write completing, so the buffer can accept the next byte back-to-back).
- SYNC bytes inside a frame are treated as ordinary data; there is no resynchronisation mid-frame.
- Arithmetic: base + index is computed in 17 bits and masked to log2(SIZE) bits. Upper wr_addr bits are 0.

## Timing
- Reset (asynchronous, any state): FSM goes to IDLE. wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, done=0, error=0, and the buffer is emptied. in_ready=1 (combinational from state). A frame in progress is abandoned without any further writes.
- wr_en, wr_addr and wr_data are registered: they assert the cycle after the payload byte is accepted and stay stable until wr_ready.
- Throughput with wr_ready tied high: one payload byte per cycle.
- A frame of N bytes takes N+6 accepted cycles. done is asserted the cycle after CSUM is accepted.
- cpu_hold rises the cycle after SYNC is accepted and falls together with the done pulse or the error set.
- done and error never assert together.

## Test plan
- Basic load: A5 10 00 04 00 01 02 03 04 04, wr_ready=1 -> four writes at addr 0x010..0x013 with data 01..04 on consecutive cycles; done pulses once; error=0; cpu_hold high for the whole frame.
- Wrap-around: base 0x0FFE, N=4, data 11 22 33 44, CSUM 0x44 -> writes at 0xFFE, 0xFFF, 0x000, 0x001; done pulses.
- Backpressure: same frame as basic load with wr_ready toggling 0/1 each cycle -> in_ready stalls, every write is held stable until accepted, no byte is lost or duplicated, done pulses.
- Bad checksum / zero length: frame with CSUM 0xFF instead of 0x04 -> all four writes still occur, error=1, no done pulse; a following A5 clears error. Frame A5 00 00 00 00 00 -> no writes, done pulses.
- Garbage and reset: send 00 FF 5A before the frame -> those bytes are discarded with no writes. Assert reset_n=0 after the second payload byte -> outputs return to reset values immediately and the remaining payload is ignored; a fresh frame afterwards loads correctly.
